// File: rtl/data_ram.sv
// data_ram: single-port RV32I load/store memory with a valid/ready request
// channel, a programmable wait-state delay and a registered response channel.
module data_ram #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int NUM_LANES = 4;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  // Access decode, all driven from the latched request.
  logic [29:0]               word_idx;
  logic [AW-1:0]             mem_idx;
  logic                      in_range, f3_bad, misalign, acc_err, do_write;
  logic [31:0]               rd_word, load_val;
  logic [7:0]                rd_byte;
  logic [15:0]               rd_half;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wlanes;

  assign word_idx = req_q.addr[31:2];
  assign mem_idx  = word_idx[AW-1:0];
  assign in_range = (word_idx < 30'(DEPTH));
  assign rd_word  = mem[mem_idx];
  assign rd_byte  = rd_word[{req_q.addr[1:0], 3'b000} +: 8];
  assign rd_half  = req_q.addr[1] ? rd_word[31:16] : rd_word[15:0];
  assign acc_err  = f3_bad | misalign | ~in_range;
  assign do_write = (state_q == S_ACCESS) && req_q.we && !acc_err;

  // Fault classification: illegal width code or address not aligned to the access size.
  always_comb begin
    f3_bad   = 1'b0;
    misalign = 1'b0;
    if (req_q.we) f3_bad = (req_q.funct3 >= 3'd3);
    else          f3_bad = (req_q.funct3 == 3'd3) || (req_q.funct3 >= 3'd6);
    case (req_q.funct3[1:0])
      2'd1:    misalign = req_q.addr[0];
      2'd2:    misalign = (req_q.addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  // Load path: pick the addressed lane(s) and sign/zero extend.
  always_comb begin
    load_val = '0;
    case (req_q.funct3)
      3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd2:    load_val = rd_word;
      3'd4:    load_val = {24'd0, rd_byte};
      3'd5:    load_val = {16'd0, rd_half};
      default: load_val = '0;
    endcase
  end

  // Store path: replicate store data across lanes and enable only the addressed ones.
  always_comb begin
    be     = '0;
    wlanes = req_q.wdata;
    case (req_q.funct3[1:0])
      2'd0: begin
        be     = 4'b0001 << req_q.addr[1:0];
        wlanes = {4{req_q.wdata[7:0]}};
      end
      2'd1: begin
        be     = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_q.wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Memory array write; contents survive reset.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (do_write && be[l]) mem[mem_idx][l] <= wlanes[l];
    end
  end

  // Transaction sequencing: accept, count wait states, access once, hold response.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          req_d       = '{we: req_we_i, funct3: req_funct3_i,
                          addr: req_addr_i, wdata: req_wdata_i};
          req_ready_d = 1'b0;
          cnt_d       = 4'(WAIT_CYCLES);
          state_d     = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = acc_err;
        rsp_rdata_d = (acc_err || req_q.we) ? 32'd0 : load_val;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
